// File: rtl/pir_display_if.sv
// pir_display_if
//  Groups the sensor/timing inputs and the display/status outputs of the
//  PIR display sequencer.
//  Signals:
//   pir_signal   raw PIR output (asynchronous to the pixel clock)
//   frame_start  1-cycle pulse at the first pixel of every frame
//   motion_mode  1 = green background, 0 = blue; frame-aligned
//   led          1 while motion is active or being held
//   motion_event 1-cycle pulse when motion is first detected from idle
//   state        sequencer state: 0 WARMUP, 1 IDLE, 2 ACTIVE, 3 HOLD
//  Modports: master drives the inputs and observes the outputs (timing
//  generator / test side); slave is the sequencer itself.
interface pir_display_if;
    logic       pir_signal;
    logic       frame_start;
    logic       motion_mode;
    logic       led;
    logic       motion_event;
    logic [1:0] state;

    modport master (
        output pir_signal, frame_start,
        input  motion_mode, led, motion_event, state
    );

    modport slave (
        input  pir_signal, frame_start,
        output motion_mode, led, motion_event, state
    );
endinterface

// File: rtl/pir_display_ctrl.sv
// pir_display_ctrl
//  Sequencer between the PIR motion sensor and the pixel colour stage.
//  Synchronises and glitch-filters the raw PIR input, runs a
//  warm-up/idle/active/hold FSM whose warm-up and hold are timed in video
//  frames, and drives a frame-aligned colour select plus an immediate LED.
//  Ports:
//   clk_148Mhz  pixel clock, all logic on the rising edge
//   reset       asynchronous, active-high
//   bus         pir_display_if.slave (pir_signal, frame_start in;
//               motion_mode, led, motion_event, state out)
//  Parameters:
//   FILTER_CYC    stable cycles required before the filtered PIR changes
//   WARMUP_FRAMES frames after reset during which PIR is ignored (0 = none)
//   HOLD_FRAMES   frames motion is held after the filtered PIR falls (>= 1)
module pir_display_ctrl #(
    parameter int FILTER_CYC    = 148500,
    parameter int WARMUP_FRAMES = 1800,
    parameter int HOLD_FRAMES   = 180
) (
    input  logic              clk_148Mhz,
    input  logic              reset,
    pir_display_if.slave      bus
);
    localparam int FW = $clog2(FILTER_CYC + 1);
    // A zero-frame warm-up still needs a 1-bit counter to keep widths legal.
    localparam int WW = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int WU_LAST_I = (WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYC - 1);
    localparam logic [WW-1:0] WU_LAST   = WW'(WU_LAST_I);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // ---------------- input synchroniser + glitch filter ----------------
    logic          sync1, pir_s, pir_f;
    logic [FW-1:0] filt_cnt;

    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            pir_s    <= 1'b0;
            pir_f    <= 1'b0;
            filt_cnt <= '0;
        end else begin
            sync1 <= bus.pir_signal;
            pir_s <= sync1;
            // Any return to the filtered level restarts the stability count,
            // so only a run of FILTER_CYC disagreeing samples flips pir_f.
            if (pir_s == pir_f) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                pir_f    <= pir_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // ---------------- sequencer FSM ----------------
    state_t        state_q, state_d;
    logic [WW-1:0] wu_cnt, wu_cnt_d;
    logic [HW-1:0] hold_cnt, hold_cnt_d;
    logic          event_d;
    logic          led_q, mode_q, event_q;

    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            state_q  <= WARMUP;
            wu_cnt   <= '0;
            hold_cnt <= '0;
            led_q    <= 1'b0;
            mode_q   <= 1'b0;
            event_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wu_cnt   <= wu_cnt_d;
            hold_cnt <= hold_cnt_d;
            event_q  <= event_d;
            // Registered from next state so led changes with state.
            led_q    <= (state_d == ACTIVE) || (state_d == HOLD);
            // Colour select only moves at a frame boundary, taking the LED
            // level current during the frame_start cycle.
            if (bus.frame_start)
                mode_q <= led_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        wu_cnt_d   = wu_cnt;
        hold_cnt_d = hold_cnt;
        event_d    = 1'b0;
        case (state_q)
            WARMUP: begin
                if (WARMUP_FRAMES == 0) begin
                    state_d = IDLE;
                end else if (bus.frame_start) begin
                    if (wu_cnt == WU_LAST) begin
                        state_d  = IDLE;
                        wu_cnt_d = '0;
                    end else begin
                        wu_cnt_d = wu_cnt + WW'(1);
                    end
                end
            end
            IDLE: begin
                if (pir_f) begin
                    state_d = ACTIVE;
                    event_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (!pir_f) begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_INIT;
                end
            end
            HOLD: begin
                // Retrigger takes priority over a coincident frame tick.
                if (pir_f) begin
                    state_d = ACTIVE;
                end else if (bus.frame_start) begin
                    if (hold_cnt == HW'(1))
                        state_d = IDLE;
                    else
                        hold_cnt_d = hold_cnt - HW'(1);
                end
            end
            default: state_d = WARMUP;
        endcase
    end

    assign bus.state        = state_q;
    assign bus.led          = led_q;
    assign bus.motion_mode  = mode_q;
    assign bus.motion_event = event_q;

endmodule

// File: tb/tb_pir_display_ctrl.sv
// tb_pir_display_ctrl
//  Directed bench for pir_display_ctrl with FILTER_CYC=8, WARMUP_FRAMES=2,
//  HOLD_FRAMES=3. frame_start is pulsed explicitly by the stimulus table so
//  frame boundaries land on exact cycles relative to the filter latency.
//  Each table row drives pir_signal for 'cyc' cycles (frame_start only in
//  the first cycle when fs=1), then checks the outputs 1 time unit after
//  the last rising edge. ev_cnt counts cycles in which motion_event was high,
//  sampled at rising edges (so it trails the current pulse by one cycle).
module tb_pir_display_ctrl;
    logic clk;
    logic rst;
    pir_display_if bus();

    pir_display_ctrl #(
        .FILTER_CYC   (8),
        .WARMUP_FRAMES(2),
        .HOLD_FRAMES  (3)
    ) dut (
        .clk_148Mhz(clk),
        .reset     (rst),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ev_cnt = 0;
    always @(posedge clk)
        if (bus.motion_event === 1'b1)
            ev_cnt <= ev_cnt + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       pir;
        logic       fs;
        int         cyc;
        logic [1:0] st;
        logic       led;
        logic       mode;
        logic       ev;
        int         cnt;
    } vec_t;

    vec_t vecs [24];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          pir   fs    cyc st    led   mode  ev    cnt
        vecs = '{
            '{1'b1, 1'b0, 20, 2'd0, 1'b0, 1'b0, 1'b0, 0},  // warm-up ignores PIR
            '{1'b1, 1'b1,  1, 2'd0, 1'b0, 1'b0, 1'b0, 0},  // 1st frame
            '{1'b1, 1'b1,  1, 2'd1, 1'b0, 1'b0, 1'b0, 0},  // 2nd frame -> IDLE
            '{1'b1, 1'b0,  1, 2'd2, 1'b1, 1'b0, 1'b1, 0},  // pir_f already high
            '{1'b1, 1'b0,  5, 2'd2, 1'b1, 1'b0, 1'b0, 1},  // event was one cycle
            '{1'b1, 1'b1,  1, 2'd2, 1'b1, 1'b1, 1'b0, 1},  // mode follows frame
            '{1'b0, 1'b0, 10, 2'd2, 1'b1, 1'b1, 1'b0, 1},  // pir_f falls at edge 10
            '{1'b0, 1'b0,  1, 2'd3, 1'b1, 1'b1, 1'b0, 1},  // HOLD
            '{1'b0, 1'b1,  1, 2'd3, 1'b1, 1'b1, 1'b0, 1},  // hold 3->2
            '{1'b0, 1'b1,  1, 2'd3, 1'b1, 1'b1, 1'b0, 1},  // hold 2->1
            '{1'b0, 1'b1,  1, 2'd1, 1'b0, 1'b1, 1'b0, 1},  // 3rd frame -> IDLE
            '{1'b0, 1'b1,  1, 2'd1, 1'b0, 1'b0, 1'b0, 1},  // next frame: blue
            '{1'b1, 1'b0,  7, 2'd1, 1'b0, 1'b0, 1'b0, 1},  // 7-cycle glitch
            '{1'b0, 1'b0, 20, 2'd1, 1'b0, 1'b0, 1'b0, 1},  // ...never seen
            '{1'b1, 1'b0,  8, 2'd1, 1'b0, 1'b0, 1'b0, 1},  // 8-cycle pulse
            '{1'b0, 1'b0,  2, 2'd1, 1'b0, 1'b0, 1'b0, 1},  // T+10: still IDLE
            '{1'b0, 1'b0,  1, 2'd2, 1'b1, 1'b0, 1'b1, 1},  // T+11: ACTIVE
            '{1'b0, 1'b0,  7, 2'd2, 1'b1, 1'b0, 1'b0, 2},  // pir_f falls again
            '{1'b0, 1'b0,  1, 2'd3, 1'b1, 1'b0, 1'b0, 2},  // HOLD, hold=3
            '{1'b0, 1'b1,  1, 2'd3, 1'b1, 1'b1, 1'b0, 2},  // hold 2, mode<=led
            '{1'b0, 1'b1,  1, 2'd3, 1'b1, 1'b1, 1'b0, 2},  // hold 1
            '{1'b1, 1'b0, 10, 2'd3, 1'b1, 1'b1, 1'b0, 2},  // pir_f rises at edge 10
            '{1'b1, 1'b1,  1, 2'd2, 1'b1, 1'b1, 1'b0, 2},  // retrigger beats frame
            '{1'b0, 1'b0, 11, 2'd3, 1'b1, 1'b1, 1'b0, 2}   // back into HOLD
        };

        rst             = 1'b1;
        bus.pir_signal  = 1'b0;
        bus.frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 32'(bus.state), 32'd0);
        check("reset led", 32'(bus.led), 32'd0);
        check("reset mode", 32'(bus.motion_mode), 32'd0);
        check("reset event", 32'(bus.motion_event), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            bus.pir_signal  = vecs[i].pir;
            bus.frame_start = vecs[i].fs;
            @(posedge clk);
            #1;
            bus.frame_start = 1'b0;
            for (int c = 1; c < vecs[i].cyc; c++) @(posedge clk);
            #1;
            check($sformatf("v%0d state", i), 32'(bus.state), 32'(vecs[i].st));
            check($sformatf("v%0d led", i), 32'(bus.led), 32'(vecs[i].led));
            check($sformatf("v%0d mode", i), 32'(bus.motion_mode), 32'(vecs[i].mode));
            check($sformatf("v%0d event", i), 32'(bus.motion_event), 32'(vecs[i].ev));
            check($sformatf("v%0d event count", i), 32'(ev_cnt), 32'(vecs[i].cnt));
        end

        // Asynchronous reset mid-cycle while in HOLD with green selected.
        #3 rst = 1'b1;
        #1;
        check("async reset state", 32'(bus.state), 32'd0);
        check("async reset led", 32'(bus.led), 32'd0);
        check("async reset mode", 32'(bus.motion_mode), 32'd0);
        check("async reset event", 32'(bus.motion_event), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Warm-up runs again from zero.
        repeat (4) @(posedge clk);
        #1;
        check("rewarm idle wait", 32'(bus.state), 32'd0);
        bus.frame_start = 1'b1;
        @(posedge clk);
        #1 bus.frame_start = 1'b0;
        check("rewarm frame 1", 32'(bus.state), 32'd0);
        repeat (5) @(posedge clk);
        #1 bus.frame_start = 1'b1;
        @(posedge clk);
        #1 bus.frame_start = 1'b0;
        check("rewarm frame 2", 32'(bus.state), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rewarm stays idle", 32'(bus.state), 32'd1);
        check("rewarm led", 32'(bus.led), 32'd0);
        check("rewarm no event", 32'(ev_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
